// File: rtl/tpu_ctrl_pkg.sv
// Shared control definitions for the systolic-array read/write wave controllers.
package tpu_ctrl_pkg;

  localparam int unsigned WIDTH_HEIGHT_DEF = 16;
  localparam int unsigned ADDR_W_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } wr_state_e;

endpackage

// File: rtl/bank_addr_ctr.sv
// Per-bank row address counter: loads the wave base address, then advances
// once for every cycle its bank is write-enabled (wraps silently).
module bank_addr_ctr
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] cnt_o
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Next count: load wins over increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = base_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + ADDR_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {ADDR_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wr_control.sv
// Output-side write-wave controller: staggered per-bank write enables and row
// addresses. Optional sticky overrun flag under WR_CONTROL_OVERRUN_EN.
module wr_control
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_HEIGHT = WIDTH_HEIGHT_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           active,
  input  logic [ADDR_W-1:0]              base_addr,
  output logic [WIDTH_HEIGHT-1:0]        wr_en,
  output logic [ADDR_W*WIDTH_HEIGHT-1:0] wr_addr,
  output logic                           busy,
  output logic                           done
`ifdef WR_CONTROL_OVERRUN_EN
  ,
  output logic                           overrun
`endif
);

  localparam int unsigned DATA_W = ADDR_W * WIDTH_HEIGHT;

  wr_state_e               state_q, state_d;
  logic [WIDTH_HEIGHT-1:0] wr_en_q, wr_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    start_s;
  logic [WIDTH_HEIGHT-1:0] shift_one_s;
  logic [WIDTH_HEIGHT-1:0] shift_zero_s;
  logic [DATA_W-1:0]       addr_s;

  assign shift_one_s  = (wr_en_q << 1'b1) | WIDTH_HEIGHT'(1'b1);
  assign shift_zero_s = wr_en_q << 1'b1;

  // Next state and next enable pattern; the drain starts on the cycle the
  // enable vector is already full, so W=1 goes straight from FILL to IDLE.
  always_comb begin
    state_d = state_q;
    wr_en_d = wr_en_q;
    done_d  = 1'b0;
    start_s = 1'b0;
    case (state_q)
      IDLE: begin
        wr_en_d = {WIDTH_HEIGHT{1'b0}};
        if (active) begin
          start_s = 1'b1;
          wr_en_d = WIDTH_HEIGHT'(1'b1);
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (&wr_en_q) begin
          wr_en_d = shift_zero_s;
          if (shift_zero_s == {WIDTH_HEIGHT{1'b0}}) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          wr_en_d = shift_one_s;
        end
      end
      DRAIN: begin
        wr_en_d = shift_zero_s;
        if (shift_zero_s == {WIDTH_HEIGHT{1'b0}}) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        wr_en_d = {WIDTH_HEIGHT{1'b0}};
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_en_q <= {WIDTH_HEIGHT{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_bank
    bank_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .load_i (start_s),
      .inc_i  (wr_en_q[gi]),
      .base_i (base_addr),
      .cnt_o  (addr_s[gi*ADDR_W +: ADDR_W])
    );
  end

`ifdef WR_CONTROL_OVERRUN_EN
  logic overrun_q;

  // Sticky flag: a start request arrived while a wave was in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_q | (active & busy_q);
    end
  end

  assign overrun = overrun_q;
`endif

  assign wr_en   = wr_en_q;
  assign wr_addr = addr_s;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/wr_control.md
Name: wr_control

Overview:
Output-side write controller for the systolic array. After the read wave completes, results emerge from the array skewed by one cycle per column. This block generates the matching staggered per-bank write enables and per-bank row addresses for the output memory array. It is the write counterpart of the input read-wave controller, and it is started by that controller's wr_active indication.

Parameters:
WIDTH_HEIGHT, 16, array dimension; also the number of output banks and rows written per bank
ADDR_W, 8, per-bank address width
localparam DATA_W = ADDR_W*WIDTH_HEIGHT, width of the packed address bus

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
active  in  1  start request; sampled only in IDLE
base_addr  in  ADDR_W  first row address for every bank; latched at start
wr_en  out  WIDTH_HEIGHT  per-bank write enable; bit i drives bank i
wr_addr  out  DATA_W  packed per-bank address; bank i is bits [i*ADDR_W +: ADDR_W]
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse when the wave completes

Behaviour:
- Reset (clk, synchronous, active-high): wr_en=0, wr_addr=0, busy=0, done=0, state=IDLE. Reset also applies mid-wave: everything is cleared on the next edge and there is no done pulse. Reset has priority over active.
- States:
  - IDLE: wr_en=0, addresses hold.
  - FILL: shift ones in from the LSB.
  - DRAIN: shift zeros in from the LSB.
- All outputs are registered. Cycle numbering below takes cycle 0 as the cycle in which active=1 is sampled in IDLE.
- Start (IDLE with active=1): every wr_addr slice is loaded with base_addr, wr_en becomes 1, state becomes FILL. Latency from active to the first enable is 1 cycle.
- FILL: wr_en <= {wr_en[W-2:0],1'b1}. When wr_en is all ones (cycle W), the next state is DRAIN.
- DRAIN: wr_en <= {wr_en[W-2:0],1'b0}. When the next value would be 0, the next state is IDLE and done=1 in that same next cycle (cycle 2W).
- Each bank is enabled for exactly W consecutive cycles. Bank i is enabled in cycles i+1 .. i+W.
- Address update: on every edge where wr_en[i]=1, slice i increments by 1, modulo 2^ADDR_W (wraps with no flag). Bank i therefore writes base..base+W-1 and ends holding base+W until the next start.
- busy=1 in cycles 1..2W-1.
- active while busy is ignored; no queueing.
- active in the cycle where done=1 is accepted, because the state is already IDLE. This gives back-to-back waves with no dead cycle beyond the done cycle.
- W=1 degenerate case: FILL lasts 1 cycle, DRAIN is skipped, done is asserted at cycle 2.

Optional Feature:
Macro WR_CONTROL_OVERRUN_EN.
- Defined: adds port overrun (out, 1). It is a sticky flag set on the edge after active=1 is sampled while busy=1, and cleared only by reset.
- Not defined: the port is absent, and active during busy is silently ignored.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package tpu_ctrl_pkg holds:
  - the state encoding (IDLE=2'd0, FILL=2'd1, DRAIN=2'd2)
  - the default WIDTH_HEIGHT and ADDR_W constants
- One natural sub-module: bank_addr_ctr, a per-bank ADDR_W counter with load (base_addr) and increment (enable) inputs. It is instantiated WIDTH_HEIGHT times via generate.
- The state machine and shift register stay in wr_control.

Test Plan:
1. W=16, base=0x00, pulse active at cycle 0 -> expected outputs:
   - cycle 1: wr_en=0x0001
   - cycle 16: wr_en=0xFFFF
   - cycle 17: wr_en=0xFFFE
   - cycle 31: wr_en=0x8000
   - cycle 32: wr_en=0x0000, done=1 for exactly one cycle
   - busy=1 in cycles 1..31
2. Same run, address check -> bank0 slice is 0x00 at cycle 1, 0x0F at cycle 16, 0x10 at cycle 17 and holds. Bank15 slice is 0x00 at cycle 16 and 0x0F at cycle 31. The write count per bank is exactly 16.
3. base=0xF8 -> bank0 slice reads 0xFF at cycle 8 and 0x00 at cycle 9 (wrap). The final value is 0x08.
4. Assert reset at cycle 10 of a wave -> cycle 11: wr_en=0, wr_addr=0, busy=0. done is never pulsed. A new active at cycle 12 restarts normally with wr_en=0x0001 at cycle 13.
5. Hold active high for cycles 0..40 -> second wave starts at cycle 32 (the done cycle), giving wr_en=0x0001 at cycle 33. Mid-wave active has no effect. With WR_CONTROL_OVERRUN_EN, overrun=1 from cycle 2 onward.
6. Pulse active at cycle 0 with reset also high -> reset wins: wr_en stays 0 and busy stays 0 at cycle 1.
